// File: rtl/pcs_tx.sv
// 1000BASE-X PCS transmit ordered-set generator: turns GMII transmit signals into a
// code-group stream ({control, octet}) for the 8b/10b encoder, one group per clock.
module pcs_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  xmit,
    input  logic        TX_EN,
    input  logic        TX_ER,
    input  logic [7:0]  TXD,
    input  logic [15:0] tx_Config_Reg,
    output logic        control,
    output logic [7:0]  data_out,
    output logic        tx_even,
    output logic        transmitting
);

    typedef enum logic [3:0] {
        IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI,
        START_OF_PACKET, TX_PACKET, END_T, EPD_R, CARRIER_EXTEND, ALIGN_R
    } state_t;

    localparam logic [1:0] XMIT_CONFIG = 2'd0;
    localparam logic [1:0] XMIT_DATA   = 2'd2;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] SYM_S = 8'hFB;
    localparam logic [7:0] SYM_T = 8'hFD;
    localparam logic [7:0] SYM_R = 8'hF7;
    localparam logic [7:0] SYM_V = 8'hFE;
    localparam logic [7:0] EXT_OCTET = 8'h0F;

    state_t      state_q, state_d;
    logic        tx_even_q;
    logic        c2_q, c2_d;
    logic [15:0] cfg_q, cfg_d;
    logic        control_q, control_d;
    logic [7:0]  data_q, data_d;
    logic        transmitting_q, transmitting_d;
    logic        at_boundary;

    // An ordered set may start only in an even slot once the previous set or the
    // end-of-packet /R/ groups are complete. IDLE_K with an even next slot only
    // occurs straight after reset.
    assign at_boundary = !tx_even_q &&
                         (state_q inside {IDLE_K, IDLE_D, CFG_HI, EPD_R, ALIGN_R});

    // NOTE: every signal assigned in this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        c2_d    = c2_q;
        cfg_d   = cfg_q;

        unique case (state_q)
            IDLE_K:                     state_d = IDLE_D;
            IDLE_D:                     state_d = IDLE_K;
            CFG_K:                      state_d = CFG_D;
            CFG_D:                      state_d = CFG_LO;
            CFG_LO:                     state_d = CFG_HI;
            CFG_HI:                     state_d = IDLE_K;
            START_OF_PACKET, TX_PACKET: state_d = TX_EN ? TX_PACKET : END_T;
            END_T, CARRIER_EXTEND:      state_d = (!TX_EN && TX_ER) ? CARRIER_EXTEND : EPD_R;
            EPD_R:                      state_d = tx_even_q ? ALIGN_R : IDLE_K;
            ALIGN_R:                    state_d = IDLE_K;
            default:                    state_d = IDLE_K;
        endcase

        // The first set after reset is always I2 or C1, never /S/.
        if (at_boundary) begin
            if (xmit == XMIT_CONFIG)
                state_d = CFG_K;
            else if (xmit == XMIT_DATA && TX_EN && state_q != IDLE_K)
                state_d = START_OF_PACKET;
            else
                state_d = IDLE_K;
        end

        if (state_d == CFG_K) begin
            c2_d  = (state_q == CFG_HI) ? !c2_q : 1'b0;
            cfg_d = tx_Config_Reg;
        end
    end

    always_comb begin
        control_d      = 1'b1;
        data_d         = K28_5;
        transmitting_d = 1'b0;

        unique case (state_d)
            IDLE_K, CFG_K: data_d = K28_5;
            IDLE_D: begin
                control_d = 1'b0;
                data_d    = D16_2;
            end
            CFG_D: begin
                control_d = 1'b0;
                data_d    = c2_d ? D2_2 : D21_5;
            end
            CFG_LO: begin
                control_d = 1'b0;
                data_d    = cfg_q[7:0];
            end
            CFG_HI: begin
                control_d = 1'b0;
                data_d    = cfg_q[15:8];
            end
            START_OF_PACKET: begin
                data_d         = SYM_S;
                transmitting_d = 1'b1;
            end
            TX_PACKET: begin
                control_d      = TX_ER;
                data_d         = TX_ER ? SYM_V : TXD;
                transmitting_d = 1'b1;
            end
            END_T: begin
                data_d         = SYM_T;
                transmitting_d = 1'b1;
            end
            CARRIER_EXTEND: begin
                data_d         = (TXD == EXT_OCTET) ? SYM_R : SYM_V;
                transmitting_d = (TXD != EXT_OCTET);
            end
            EPD_R, ALIGN_R: data_d = SYM_R;
            default: begin
                control_d = 1'b0;
                data_d    = 8'h00;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE_K;
            tx_even_q      <= 1'b0;
            c2_q           <= 1'b0;
            cfg_q          <= 16'h0000;
            control_q      <= 1'b0;
            data_q         <= 8'h00;
            transmitting_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tx_even_q      <= !tx_even_q;
            c2_q           <= c2_d;
            cfg_q          <= cfg_d;
            control_q      <= control_d;
            data_q         <= data_d;
            transmitting_q <= transmitting_d;
        end
    end

    assign control      = control_q;
    assign data_out     = data_q;
    assign tx_even      = tx_even_q;
    assign transmitting = transmitting_q;

endmodule

// File: tb/tb_pcs_tx.sv
// Scoreboard bench for pcs_tx: each stimulus cycle queues its hand-computed
// code-group; a monitor pops one entry per clock and compares.
module tb_pcs_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  xmit;
    logic        TX_EN;
    logic        TX_ER;
    logic [7:0]  TXD;
    logic [15:0] tx_Config_Reg;
    logic        control;
    logic [7:0]  data_out;
    logic        tx_even;
    logic        transmitting;

    always #5 clk = ~clk;

    pcs_tx dut (
        .clk           (clk),
        .reset         (reset),
        .xmit          (xmit),
        .TX_EN         (TX_EN),
        .TX_ER         (TX_ER),
        .TXD           (TXD),
        .tx_Config_Reg (tx_Config_Reg),
        .control       (control),
        .data_out      (data_out),
        .tx_even       (tx_even),
        .transmitting  (transmitting)
    );

    typedef struct {
        logic       ctl;
        logic [7:0] dat;
        logic       ev;
        logic       trn;
        int         id;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          vec_id = 0;
    logic        ev_m = 1'b0;
    logic [15:0] cfg_next = 16'h0000;

    // One stimulus cycle: drive on the falling edge, queue the group expected
    // after the following rising edge.
    task automatic cyc(input logic rst, input logic [1:0] xm, input logic en,
                       input logic er, input logic [7:0] d, input logic ctl,
                       input logic [7:0] dat, input logic trn);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        xmit          = xm;
        TX_EN         = en;
        TX_ER         = er;
        TXD           = d;
        tx_Config_Reg = cfg_next;
        ev_m          = rst ? 1'b0 : !ev_m;
        e.ctl = ctl;
        e.dat = dat;
        e.ev  = ev_m;
        e.trn = trn;
        e.id  = vec_id;
        vec_id++;
        sb_q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        total++;
        if (control !== e.ctl || data_out !== e.dat || tx_even !== e.ev ||
            transmitting !== e.trn) begin
            bad++;
            $display("FAIL vec%0d: got ctl=%b data=%h even=%b tx=%b, want ctl=%b data=%h even=%b tx=%b",
                     e.id, control, data_out, tx_even, transmitting, e.ctl, e.dat, e.ev, e.trn);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e);
            end
        end
    end

    initial begin
        reset = 1'b1; xmit = 2'd0; TX_EN = 1'b0; TX_ER = 1'b0; TXD = 8'h00;
        tx_Config_Reg = 16'h0000;

        // Reset, then configuration C1/C2/C1 with a mid-set config change
        cfg_next = 16'h41A0;
        cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        cyc(1, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'hB5, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'hA0, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h41, 0);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h42, 0);
        cfg_next = 16'h1234;
        cyc(0, 0, 0, 0, 8'h00, 0, 8'hA0, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h41, 0);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'hB5, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h34, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h12, 0);

        // DATA mode idle, then an even-aligned packet needing an alignment /R/
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 2, 0, 0, 8'h00, 0, 8'h50, 0);
        cyc(0, 2, 1, 0, 8'h55, 1, 8'hFB, 1);
        cyc(0, 2, 1, 0, 8'h55, 0, 8'h55, 1);
        cyc(0, 2, 1, 0, 8'h55, 0, 8'h55, 1);
        cyc(0, 2, 1, 0, 8'hD5, 0, 8'hD5, 1);
        cyc(0, 2, 1, 0, 8'h11, 0, 8'h11, 1);
        cyc(0, 2, 1, 0, 8'h22, 0, 8'h22, 1);
        cyc(0, 2, 1, 0, 8'h33, 0, 8'h33, 1);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hFD, 1);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hF7, 0);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hF7, 0);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 2, 0, 0, 8'h00, 0, 8'h50, 0);

        // One error cycle mid-packet; xmit moves to CONFIGURATION during the packet
        cyc(0, 2, 1, 0, 8'h55, 1, 8'hFB, 1);
        cyc(0, 2, 1, 0, 8'hD5, 0, 8'hD5, 1);
        cyc(0, 0, 1, 1, 8'h01, 1, 8'hFE, 1);
        cyc(0, 0, 1, 0, 8'h02, 0, 8'h02, 1);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'hFD, 1);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'hF7, 0);
        cyc(0, 0, 0, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'hB5, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h34, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 8'h12, 0);

        // TX_EN rises in the odd half of an I2 set: octet dropped, /S/ next even
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 2, 0, 0, 8'h00, 0, 8'h50, 0);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 2, 1, 0, 8'h55, 0, 8'h50, 0);
        cyc(0, 2, 1, 0, 8'h55, 1, 8'hFB, 1);
        cyc(0, 2, 1, 0, 8'hD5, 0, 8'hD5, 1);
        cyc(0, 2, 1, 0, 8'hAA, 0, 8'hAA, 1);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hFD, 1);

        // Carrier extension for three cycles, then the closing /R/
        cyc(0, 2, 0, 1, 8'h0F, 1, 8'hF7, 0);
        cyc(0, 2, 0, 1, 8'h0F, 1, 8'hF7, 0);
        cyc(0, 2, 0, 1, 8'h0F, 1, 8'hF7, 0);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hF7, 0);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 2, 0, 0, 8'h00, 0, 8'h50, 0);

        // TX_EN rising during END_T is held off until the even boundary
        cyc(0, 2, 1, 0, 8'h55, 1, 8'hFB, 1);
        cyc(0, 2, 1, 0, 8'h66, 0, 8'h66, 1);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hFD, 1);
        cyc(0, 2, 1, 0, 8'h77, 1, 8'hF7, 0);
        cyc(0, 2, 1, 0, 8'h88, 1, 8'hFB, 1);
        cyc(0, 2, 1, 0, 8'h99, 0, 8'h99, 1);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hFD, 1);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hF7, 0);

        // Reset mid-packet, I2 first after reset even with TX_EN high, then xmit=3/1
        cyc(0, 2, 1, 0, 8'h55, 1, 8'hFB, 1);
        cyc(0, 2, 1, 0, 8'h12, 0, 8'h12, 1);
        cyc(1, 2, 1, 0, 8'h34, 0, 8'h00, 0);
        cyc(0, 2, 1, 0, 8'h56, 1, 8'hBC, 0);
        cyc(0, 2, 1, 0, 8'h78, 0, 8'h50, 0);
        cyc(0, 2, 1, 0, 8'h9A, 1, 8'hFB, 1);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hFD, 1);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hF7, 0);
        cyc(0, 2, 0, 0, 8'h00, 1, 8'hF7, 0);
        cyc(0, 3, 1, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 3, 1, 0, 8'h00, 0, 8'h50, 0);
        cyc(0, 1, 1, 0, 8'h00, 1, 8'hBC, 0);
        cyc(0, 1, 1, 0, 8'h00, 0, 8'h50, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcs_tx.md
PCS_TX -- requirements
Module: pcs_tx

Interface
- REQ-001 SHALL provide port `clk`, input, 1 bit: single clock; one code-group is issued per rising edge.
- REQ-002 SHALL provide port `reset`, input, 1 bit: synchronous, active-high reset.
- REQ-003 SHALL provide port `xmit`, input, 2 bits: 0 = CONFIGURATION, 1 = IDLE, 2 = DATA; 3 is treated as IDLE.
- REQ-004 SHALL provide port `TX_EN`, input, 1 bit: GMII transmit enable.
- REQ-005 SHALL provide port `TX_ER`, input, 1 bit: GMII transmit error / carrier-extend qualifier.
- REQ-006 SHALL provide port `TXD`, input, 8 bits: GMII transmit octet.
- REQ-007 SHALL provide port `tx_Config_Reg`, input, 16 bits: autonegotiation word to send in /C/ ordered sets.
- REQ-008 SHALL provide port `control`, output reg, 1 bit: 1 = the current code-group is a K special, 0 = a D data group.
- REQ-009 SHALL provide port `data_out`, output reg, 8 bits: octet value of the current code-group, to the 8b/10b encoder.
- REQ-010 SHALL provide port `tx_even`, output reg, 1 bit: 1 when the current group occupies an even position.
- REQ-011 SHALL provide port `transmitting`, output reg, 1 bit: high while packet groups are issued.

Function
- REQ-012 SHALL register all outputs and SHALL apply a one-cycle latency from the sampled inputs to the issued code-group.
- REQ-013 SHALL toggle `tx_even` every cycle.
- REQ-014 SHALL issue /K28.5/ ({1,BC}) only with `tx_even`=1.
- REQ-015 SHALL use these code-group encodings:
  - I2 = K28.5, D16.2 ({0,50})
  - C1 = K28.5, D21.5 ({0,B5}), Config_Reg[7:0], Config_Reg[15:8]
  - C2 = K28.5, D2.2 ({0,42}), Config_Reg[7:0], Config_Reg[15:8]
  - /S/ = {1,FB}; /T/ = {1,FD}; /R/ = {1,F7}; /V/ = {1,FE}
- REQ-016 SHALL implement these states: IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI, START_OF_PACKET, TX_PACKET, END_T, EPD_R, CARRIER_EXTEND, ALIGN_R.
- REQ-017 SHALL sample `xmit` only at ordered-set boundaries, i.e. when the next group is even and no packet is in progress; a set that has started SHALL always complete.
- REQ-018 In CONFIGURATION mode, SHALL send C1 and C2 sets alternately, starting with C1 after entering the mode.
- REQ-019 SHALL capture `tx_Config_Reg` on the K28.5 cycle of each /C/ set and SHALL hold it for the remainder of that set.
- REQ-020 In IDLE mode, SHALL send I2 sets repeatedly and SHALL ignore `TX_EN`.
- REQ-021 In DATA mode with `TX_EN`=0, SHALL send I2 sets.
- REQ-022 In DATA mode, SHALL emit /S/ in the first even slot at or after `TX_EN` rises.
  - /S/ replaces the octet sampled in that cycle.
  - Preamble octets sampled while an I2 set completes SHALL be discarded.
- REQ-023 In TX_PACKET:
  - `TX_EN`=1 and `TX_ER`=0 → issue {0,TXD}.
  - `TX_EN`=1 and `TX_ER`=1 → issue /V/.
- REQ-024 When `TX_EN` falls:
  - SHALL issue /T/, then /R/.
  - If the slot after that /R/ is odd, SHALL issue one further /R/ (ALIGN_R), so that the next K28.5 lands even.
- REQ-025 Carrier extension:
  - While `TX_EN`=0, `TX_ER`=1 and `TXD`=0x0F after /T/, SHALL issue /R/ each cycle.
  - `TX_EN`=0, `TX_ER`=1 with any other `TXD` SHALL issue /V/.
  - On `TX_ER` falling, SHALL issue /R/ plus an alignment /R/ where REQ-024 requires it.
- REQ-026 SHALL drive `transmitting`=1 for each /S/, data, /V/ and /T/ group, and 0 otherwise.
- REQ-027 A change of `xmit` during a packet SHALL be deferred until the idle boundary following the end-of-packet /R/ groups.
- REQ-028 `TX_EN` rising during END_T, EPD_R or ALIGN_R SHALL be ignored until an even boundary, then SHALL be handled per REQ-022.

Reset
- REQ-029 While `reset` is high, outputs SHALL be:
  - `control`=0, `data_out`=0x00
  - `tx_even`=0, `transmitting`=0
  - state = IDLE_K
- REQ-030 Reset mid-packet or mid-set SHALL abort immediately, with no /T/ or /R/ issued.
- REQ-031 The first cycle after reset deasserts SHALL issue {1,BC} with `tx_even`=1.
  - That set is I2 if `xmit`≠0.
  - That set is C1 if `xmit`=0.

Verification
- REQ-032 SHALL verify: `xmit`=0, `tx_Config_Reg`=0x41A0, reset released → BC,B5,A0,41,BC,42,A0,41 repeating, with BC always even.
- REQ-033 SHALL verify: `xmit`=2; `TX_EN` asserted with a 55-octet preamble sequence aligned even, then D5 and 3 data octets, then `TX_EN`=0 → FB, remaining octets, FD, F7, F7(align) as required, BC, 50; `transmitting` high over FB..FD.
- REQ-034 SHALL verify: `TX_EN` rises while an I2 set is mid-way (odd slot) → 50 is issued, the first octet is dropped, FB is issued on the next even slot.
- REQ-035 SHALL verify: `TX_ER`=1 for one data cycle → exactly one {1,FE}; the packet continues.
- REQ-036 SHALL verify: `TX_EN`=0, `TX_ER`=1, `TXD`=0F for 3 cycles after the packet → FD, F7 ×3 (plus alignment), then BC on an even slot.
- REQ-037 SHALL verify: `xmit` switched 2→0 during a packet → the packet finishes with FD/F7, then C1 begins at an even slot.
- REQ-038 SHALL verify: `reset` asserted mid-packet → outputs return to reset values on the next edge.
